// File: rtl/sync_fifo_rd_stream.sv
// rtl/sync_fifo_rd_stream.sv - sync_fifo read side to valid/ready stream with 3-entry skid buffer
module sync_fifo_rd_stream #(
    parameter int Width = 16,
    parameter int Burst = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [Width-1:0] fifo_dout,
    output logic             fifo_r_enb,
    output logic [Width-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [15:0]      word_cnt
);

    localparam int BcntW = (Burst > 1) ? $clog2(Burst) : 1;
    localparam logic [BcntW-1:0] BcntMax = BcntW'(Burst - 1);

    logic [1:0]       occ_q, occ_d;
    logic [1:0]       head_q, head_d;
    logic [1:0]       tail_q, tail_d;
    logic             pend_q, pend_d;
    logic [BcntW-1:0] bcnt_q, bcnt_d;
    logic [15:0]      word_cnt_q, word_cnt_d;
    logic [Width-1:0] mem_q [3];
    logic [Width-1:0] mem_d [3];

    logic [2:0] inflight;
    logic       handshake;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        // Buffered words plus the word still in flight from the FIFO never exceed the buffer depth.
        inflight   = {1'b0, occ_q} + {2'b00, pend_q};
        fifo_r_enb = !reset && !fifo_empty && (inflight < 3'd3);
        m_valid    = (occ_q != 2'd0);
        m_data     = mem_q[head_q];
        m_last     = m_valid && (bcnt_q == BcntMax);
        word_cnt   = word_cnt_q;
        handshake  = m_valid && m_ready;

        pend_d     = fifo_r_enb;
        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;
        bcnt_d     = bcnt_q;
        word_cnt_d = word_cnt_q;
        for (int i = 0; i < 3; i++) begin
            mem_d[i] = mem_q[i];
        end

        if (pend_q) begin
            mem_d[tail_q] = fifo_dout;
            tail_d        = ptr_inc(tail_q);
        end
        if (handshake) begin
            head_d     = ptr_inc(head_q);
            word_cnt_d = word_cnt_q + 16'd1;
            bcnt_d     = m_last ? '0 : bcnt_q + 1'b1;
        end
        if (pend_q && !handshake) begin
            occ_d = occ_q + 2'd1;
        end else if (!pend_q && handshake) begin
            occ_d = occ_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q      <= 2'd0;
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
            pend_q     <= 1'b0;
            bcnt_q     <= '0;
            word_cnt_q <= 16'd0;
        end else begin
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            pend_q     <= pend_d;
            bcnt_q     <= bcnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Storage needs no reset: m_data is only meaningful while m_valid is high.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

endmodule
